// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flop, reused
// over WIDTH cycles LSB first, with parallel load on start and parallel result on done.
module serial_addsub #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             s_bit;
    logic             c_next;
    logic [WIDTH-1:0] res_next;

    // The single full-adder cell shared by every bit position.
    assign s_bit    = a_sr[0] ^ b_sr[0] ^ carry;
    assign c_next   = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    assign res_next = {s_bit, res_sr[WIDTH-1:1]};

    assign busy = (state == SHIFT);

    // NOTE: all state here is sequential, so every assignment in this block is
    // non-blocking; mixing in blocking writes would make ordering simulation-dependent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b ^ {WIDTH{sub}};
                        carry <= cin;
                        cnt   <= '0;
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_next;
                    carry  <= c_next;
                    if (cnt == CW'(WIDTH - 1)) begin
                        // On the MSB cycle the carry flop holds the carry into the MSB.
                        sum   <= res_next;
                        cout  <= c_next;
                        ovf   <= carry ^ c_next;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: a scoreboard queue of model results is
// filled on each accepted start and drained whenever done pulses.
module tb_serial_addsub;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    serial_addsub #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference arithmetic done at full width, overflow from operand/result signs.
    function automatic exp_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                   input logic sv, input logic cv);
        exp_t             e;
        logic [WIDTH-1:0] bb;
        logic [WIDTH:0]   full;
        bb     = bv ^ {WIDTH{sv}};
        full   = {1'b0, av} + {1'b0, bb} + {{WIDTH{1'b0}}, cv};
        e.sum  = full[WIDTH-1:0];
        e.cout = full[WIDTH];
        e.ovf  = (av[WIDTH-1] == bb[WIDTH-1]) && (full[WIDTH-1] != av[WIDTH-1]);
        return e;
    endfunction

    // Result monitor: every done must match the oldest outstanding expectation.
    exp_t mon_e;
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 32'(done), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("sum",  32'(sum),  32'(mon_e.sum));
                check("cout", 32'(cout), 32'(mon_e.cout));
                check("ovf",  32'(ovf),  32'(mon_e.ovf));
            end
        end
    end

    task automatic issue(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                         input logic sv, input logic cv);
        @(negedge clk);
        a = av; b = bv; sub = sv; cin = cv; start = 1'b1;
        sb.push_back(model(av, bv, sv, cv));
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns the number of rising edges from the accept edge up to the done cycle.
    task automatic wait_done(output int n);
        n = 1;
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        if (!done) check("done_timeout", 32'(done), 32'd1);
    endtask

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             sub;
        logic             cin;
    } vec_t;

    vec_t vecs[4] = '{
        '{4'd7,  4'd2, 1'b1, 1'b1},
        '{4'd3,  4'd5, 1'b1, 1'b1},
        '{4'd15, 4'd1, 1'b0, 1'b0},
        '{4'd15, 4'd15, 1'b0, 1'b1}
    };

    initial begin
        int   n;
        int   bc;
        int   g;
        exp_t last;

        rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum",  32'(sum),  32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf",  32'(ovf),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic add, latency from accept edge to done.
        issue(4'd5, 4'd3, 1'b0, 1'b0);
        check("busy_after_accept", 32'(busy), 32'd1);
        wait_done(n);
        check("latency", 32'(n), 32'(WIDTH + 1));
        last = model(4'd5, 4'd3, 1'b0, 1'b0);

        // Subtract and wrap-around cases.
        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin);
            wait_done(n);
            last = model(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin);
        end
        repeat (3) @(negedge clk);
        check("sum_held_idle", 32'(sum), 32'(last.sum));
        check("busy_idle", 32'(busy), 32'd0);

        // Start pulsed mid-SHIFT must be ignored.
        issue(4'd6, 4'd7, 1'b0, 1'b0);
        bc = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (busy) bc++;
            if (i == 1) begin
                check("sum_held_shift", 32'(sum), 32'(last.sum));
                a = 4'd1; b = 4'd1; sub = 1'b1; cin = 1'b1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("busy_cycles", 32'(bc), 32'(WIDTH));
        last = model(4'd6, 4'd7, 1'b0, 1'b0);
        repeat (6) @(negedge clk);
        check("busy_after_ignored", 32'(busy), 32'd0);

        // Start held through DONE: back-to-back ops.
        @(negedge clk);
        a = 4'd2; b = 4'd3; sub = 1'b0; cin = 1'b0; start = 1'b1;
        sb.push_back(model(4'd2, 4'd3, 1'b0, 1'b0));
        @(negedge clk);
        a = 4'd9; b = 4'd4; sub = 1'b1; cin = 1'b1;
        wait_done(n);
        check("b2b_latency", 32'(n), 32'(WIDTH + 1));
        sb.push_back(model(4'd9, 4'd4, 1'b1, 1'b1));
        last = model(4'd2, 4'd3, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        check("b2b_accepted", 32'(busy), 32'd1);
        check("sum_held_b2b", 32'(sum), 32'(last.sum));
        g = 1;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            g++;
        end
        check("done_spacing", 32'(g), 32'(WIDTH + 1));
        last = model(4'd9, 4'd4, 1'b1, 1'b1);

        // Reset in the middle of SHIFT aborts the operation.
        issue(4'd4, 4'd4, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum",  32'(sum),  32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        check("abort_ovf",  32'(ovf),  32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("abort_no_done", 32'(done), 32'd0);

        issue(4'd3, 4'd5, 1'b1, 1'b1);
        wait_done(n);
        check("post_reset_latency", 32'(n), 32'(WIDTH + 1));
        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
